mk8_param_bank_ram: RTL and testbench
=====================================

# mk8_param_bank_ram

Double-buffered, parametrised parameter RAM between the CPU Avalon-MM slave (port A) and the coil-driver TX engine (port B). The CPU edits a shadow bank while the TX engine reads a stable active bank. A commit request swaps the banks atomically at the next TX frame boundary. A copy engine then refreshes the new shadow bank from the new active bank, so CPU partial edits always start from the live image.

## Interface
- DATA_W, 32, word width; multiple of 8
- ADDR_W, 11, address width, both ports
- DEPTH, 1025, words per bank; ≤ 2^ADDR_W, need not be a power of two
- BE_W, DATA_W/8, byte-enable width (derived)

Ports:
- clk  in  1  single clock for all logic
- reset  in  1  synchronous, active-high
- a_address  in  ADDR_W  CPU word address (shadow bank)
- a_chipselect  in  1  CPU select
- a_read  in  1  CPU read strobe
- a_write  in  1  CPU write strobe
- a_byteenable  in  BE_W  CPU write byte lanes
- a_writedata  in  DATA_W  CPU write data
- a_readdata  out  DATA_W  CPU read data
- a_readdatavalid  out  1  a_readdata valid
- a_waitrequest  out  1  CPU stall
- b_address  in  ADDR_W  TX word address (active bank)
- b_read  in  1  TX read strobe
- b_readdata  out  DATA_W  TX read data
- b_readdatavalid  out  1  b_readdata valid
- commit_req  in  1  single-cycle commit pulse
- b_frame_done  in  1  single-cycle TX frame-boundary pulse
- commit_busy  out  1  high whenever the FSM is not in IDLE
- active_bank  out  1  bank currently read by port B

## Operation
- Storage: two banks of DEPTH × DATA_W. Memory contents are not reset.
- Port A access:
  - Accepted when a_chipselect & (a_read | a_write) & !a_waitrequest.
  - Writes go to the shadow bank (!active_bank) and honour a_byteenable.
  - Reads return shadow-bank data.
- Port B access: accepted whenever b_read is high; reads the active bank only. Port B has no write path.
- Addresses ≥ DEPTH:
  - Writes are dropped.
  - Reads return 0, still with a valid pulse.
- FSM states:
  - IDLE: on commit_req → PEND.
  - PEND: wait for b_frame_done → SWAP. A b_frame_done in the same cycle as the accepting commit_req is ignored.
  - SWAP: one cycle. active_bank toggles at the end of this cycle. → COPY.
  - COPY: count i = 0..DEPTH-1. Read active[i], then write shadow[i] one cycle later. Runs DEPTH+1 cycles, then → IDLE.
- a_waitrequest:
  - High in PEND, SWAP and COPY, so the committed image is exactly the shadow contents at commit_req.
  - Low in IDLE.
- commit_req outside IDLE is ignored; commit_busy reports this condition.
- Port B is never stalled. A read presented in the SWAP cycle uses the pre-swap bank.
- Reset:
  - State → IDLE; active_bank, commit_busy, a_waitrequest, both readdatavalid and both readdata → 0.
  - A copy aborted by reset leaves the shadow bank partially refreshed (undefined). Software must re-initialise it.

## Timing
- Port A read latency: 1 cycle. a_readdatavalid is high in the cycle after acceptance.
- Port B read latency: 1 cycle, same rule.
- commit_req → PEND on the next edge.
- b_frame_done in PEND → SWAP on the next edge.
- First B read returning new-bank data: issued in the cycle after SWAP.
- Commit duration: from the SWAP cycle to commit_busy low is 1 + (DEPTH+1) cycles. a_waitrequest falls in the same cycle as commit_busy.
- Copy engine uses the second port of each bank; it does not contend with port B.

## Structure
- Package mk8_param_pkg:
  - FSM state enum {IDLE, PEND, SWAP, COPY}
  - Default DATA_W, ADDR_W, DEPTH constants
- Sub-module mk8_param_dpram, instantiated once per bank:
  - True dual-port RAM with 1-cycle registered read and byte enables, ports X and Y.
- Port mapping:
  - Active bank: X serves port B, Y serves copy reads.
  - Shadow bank: X serves port A, Y serves copy writes.
- Top level contains the FSM, copy counter, port muxes and the out-of-range guard.

## Test plan
- Reset, then A writes 0xDEADBEEF to address 5 with byteenable 4'b0011, then A reads address 5 → 0x0000BEEF after 1 cycle (shadow initialised to 0 by the bench). B reads address 5 from bank 0 → unaffected.
- A fills shadow addresses 0..DEPTH-1 with value i, pulses commit_req, then pulses b_frame_done 20 cycles later:
  - a_waitrequest is high from PEND onward.
  - active_bank toggles after SWAP.
  - B read of address 7 → 7.
  - commit_busy is low exactly DEPTH+2 cycles after SWAP.
- After the commit, A reads shadow address 100 → 100 (copy-back correct). A write to address 100 does not change B's read of address 100.
- commit_req and b_frame_done asserted in the same cycle:
  - The FSM stays in PEND.
  - A second commit_req in PEND is ignored.
  - The swap occurs only on the next b_frame_done.
- A write to address 1025 is dropped. A and B reads of address 2047 → 0 with valid asserted.
- reset asserted at copy index 300:
  - All outputs → 0 next cycle; active_bank → 0.
  - A access is accepted immediately after reset release.

Source files
------------

// File: rtl/mk8_param_pkg.sv
// Shared types and default geometry for the double-buffered parameter RAM.
package mk8_param_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 11;
  localparam int DEF_DEPTH  = 1025;

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    SWAP,
    COPY
  } state_t;

endpackage

// File: rtl/mk8_param_dpram.sv
// True dual-port RAM bank: ports X and Y, byte-enabled writes, 1-cycle registered reads.
module mk8_param_dpram
  import mk8_param_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int BE_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              x_en,
  input  logic              x_we,
  input  logic [BE_W-1:0]   x_be,
  input  logic [ADDR_W-1:0] x_addr,
  input  logic [DATA_W-1:0] x_wdata,
  output logic [DATA_W-1:0] x_rdata,
  input  logic              y_en,
  input  logic              y_we,
  input  logic [BE_W-1:0]   y_be,
  input  logic [ADDR_W-1:0] y_addr,
  input  logic [DATA_W-1:0] y_wdata,
  output logic [DATA_W-1:0] y_rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Both ports share one process so the array has a single writer; reads return old data.
  always_ff @(posedge clk) begin
    if (x_en) begin
      x_rdata <= mem[x_addr];
      if (x_we) begin
        for (int b = 0; b < BE_W; b++) begin
          if (x_be[b]) mem[x_addr][b*8 +: 8] <= x_wdata[b*8 +: 8];
        end
      end
    end
    if (y_en) begin
      y_rdata <= mem[y_addr];
      if (y_we) begin
        for (int b = 0; b < BE_W; b++) begin
          if (y_be[b]) mem[y_addr][b*8 +: 8] <= y_wdata[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/mk8_param_bank_ram.sv
// Double-buffered parameter RAM: CPU edits the shadow bank, TX reads the active bank,
// commit swaps banks at a frame boundary and then copies active back into shadow.
module mk8_param_bank_ram
  import mk8_param_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int BE_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] a_address,
  input  logic              a_chipselect,
  input  logic              a_read,
  input  logic              a_write,
  input  logic [BE_W-1:0]   a_byteenable,
  input  logic [DATA_W-1:0] a_writedata,
  output logic [DATA_W-1:0] a_readdata,
  output logic              a_readdatavalid,
  output logic              a_waitrequest,
  input  logic [ADDR_W-1:0] b_address,
  input  logic              b_read,
  output logic [DATA_W-1:0] b_readdata,
  output logic              b_readdatavalid,
  input  logic              commit_req,
  input  logic              b_frame_done,
  output logic              commit_busy,
  output logic              active_bank
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  state_t state, next_state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] wr_idx;
  logic a_in_range, b_in_range, a_acc, a_rd, a_wr, copy_rd, copy_wr;
  logic a_oor_q, a_bank_q, b_oor_q, b_bank_q;

  logic              x_en    [2];
  logic              x_we    [2];
  logic [BE_W-1:0]   x_be    [2];
  logic [ADDR_W-1:0] x_addr  [2];
  logic [DATA_W-1:0] x_wdata [2];
  logic [DATA_W-1:0] x_rdata [2];
  logic              y_en    [2];
  logic              y_we    [2];
  logic [BE_W-1:0]   y_be    [2];
  logic [ADDR_W-1:0] y_addr  [2];
  logic [DATA_W-1:0] y_wdata [2];
  logic [DATA_W-1:0] y_rdata [2];

  assign commit_busy   = (state != IDLE);
  assign a_waitrequest = commit_busy;

  assign a_in_range = ({1'b0, a_address} < DEPTH_C);
  assign b_in_range = ({1'b0, b_address} < DEPTH_C);
  assign a_acc      = a_chipselect & (a_read | a_write) & ~a_waitrequest;
  assign a_rd       = a_acc & a_read;
  assign a_wr       = a_acc & a_write & a_in_range;

  // Copy pipeline: read active[cnt], write shadow[cnt-1] from the registered read data.
  assign copy_rd = (state == COPY) && (cnt < DEPTH_C);
  assign copy_wr = (state == COPY) && (cnt != '0);
  assign wr_idx  = ADDR_W'(cnt - 1'b1);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (commit_req)    next_state = PEND;
      PEND: if (b_frame_done)  next_state = SWAP;
      SWAP:                    next_state = COPY;
      COPY: if (cnt == DEPTH_C) next_state = IDLE;
      default:                 next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_bank     <= 1'b0;
      cnt             <= '0;
      a_readdatavalid <= 1'b0;
      b_readdatavalid <= 1'b0;
      a_oor_q         <= 1'b0;
      a_bank_q        <= 1'b0;
      b_oor_q         <= 1'b0;
      b_bank_q        <= 1'b0;
    end else begin
      if (state == SWAP) active_bank <= ~active_bank;
      cnt             <= (state == COPY) ? cnt + 1'b1 : '0;
      a_readdatavalid <= a_rd;
      a_oor_q         <= ~a_in_range;
      a_bank_q        <= ~active_bank;
      b_readdatavalid <= b_read;
      b_oor_q         <= ~b_in_range;
      b_bank_q        <= active_bank;
    end
  end

  // Active bank: X serves TX reads, Y copy reads. Shadow bank: X serves CPU, Y copy writes.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      x_en[i]    = 1'b0;
      x_we[i]    = 1'b0;
      x_be[i]    = '0;
      x_addr[i]  = '0;
      x_wdata[i] = '0;
      y_en[i]    = 1'b0;
      y_we[i]    = 1'b0;
      y_be[i]    = '0;
      y_addr[i]  = '0;
      y_wdata[i] = '0;
      if (active_bank == 1'(i)) begin
        x_en[i]   = b_read & b_in_range;
        x_addr[i] = b_address;
        y_en[i]   = copy_rd;
        y_addr[i] = cnt[ADDR_W-1:0];
      end else begin
        x_en[i]    = (a_rd & a_in_range) | a_wr;
        x_we[i]    = a_wr;
        x_be[i]    = a_byteenable;
        x_addr[i]  = a_address;
        x_wdata[i] = a_writedata;
        y_en[i]    = copy_wr;
        y_we[i]    = copy_wr;
        y_be[i]    = '1;
        y_addr[i]  = wr_idx;
        y_wdata[i] = y_rdata[active_bank];
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    mk8_param_dpram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
    ) u_bank (
      .clk     (clk),
      .x_en    (x_en[g]),
      .x_we    (x_we[g]),
      .x_be    (x_be[g]),
      .x_addr  (x_addr[g]),
      .x_wdata (x_wdata[g]),
      .x_rdata (x_rdata[g]),
      .y_en    (y_en[g]),
      .y_we    (y_we[g]),
      .y_be    (y_be[g]),
      .y_addr  (y_addr[g]),
      .y_wdata (y_wdata[g]),
      .y_rdata (y_rdata[g])
    );
  end

  // Readdata is forced to zero unless valid, so reset and out-of-range reads both read 0.
  assign a_readdata = (a_readdatavalid && !a_oor_q) ? x_rdata[a_bank_q] : '0;
  assign b_readdata = (b_readdatavalid && !b_oor_q) ? x_rdata[b_bank_q] : '0;

endmodule

// File: tb/tb_mk8_param_bank_ram.sv
// Self-checking bench for mk8_param_bank_ram against a per-bank array model.
module tb_mk8_param_bank_ram;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 11;
  localparam int DEPTH  = 1025;
  localparam int BE_W   = DATA_W / 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [ADDR_W-1:0] a_address = '0;
  logic              a_chipselect = 1'b0;
  logic              a_read = 1'b0;
  logic              a_write = 1'b0;
  logic [BE_W-1:0]   a_byteenable = '0;
  logic [DATA_W-1:0] a_writedata = '0;
  logic [DATA_W-1:0] a_readdata;
  logic              a_readdatavalid;
  logic              a_waitrequest;
  logic [ADDR_W-1:0] b_address = '0;
  logic              b_read = 1'b0;
  logic [DATA_W-1:0] b_readdata;
  logic              b_readdatavalid;
  logic              commit_req = 1'b0;
  logic              b_frame_done = 1'b0;
  logic              commit_busy;
  logic              active_bank;

  int checks = 0;
  int fails  = 0;

  // Model: physical bank contents plus which bank the TX side reads.
  logic [DATA_W-1:0] bank_m [2][DEPTH];
  int act_m = 0;

  mk8_param_bank_ram dut (
    .clk             (clk),
    .reset           (reset),
    .a_address       (a_address),
    .a_chipselect    (a_chipselect),
    .a_read          (a_read),
    .a_write         (a_write),
    .a_byteenable    (a_byteenable),
    .a_writedata     (a_writedata),
    .a_readdata      (a_readdata),
    .a_readdatavalid (a_readdatavalid),
    .a_waitrequest   (a_waitrequest),
    .b_address       (b_address),
    .b_read          (b_read),
    .b_readdata      (b_readdata),
    .b_readdatavalid (b_readdatavalid),
    .commit_req      (commit_req),
    .b_frame_done    (b_frame_done),
    .commit_busy     (commit_busy),
    .active_bank     (active_bank)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] observed,
                             input logic [DATA_W-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  function automatic logic [DATA_W-1:0] expA(input int addr);
    return (addr < DEPTH) ? bank_m[1 - act_m][addr] : '0;
  endfunction

  function automatic logic [DATA_W-1:0] expB(input int addr);
    return (addr < DEPTH) ? bank_m[act_m][addr] : '0;
  endfunction

  task automatic modelCommit();
    act_m = 1 - act_m;
    for (int i = 0; i < DEPTH; i++) bank_m[1 - act_m][i] = bank_m[act_m][i];
  endtask

  task automatic applyStimulus(input int addr, input logic [DATA_W-1:0] data,
                               input logic [BE_W-1:0] be);
    a_chipselect = 1'b1;
    a_write      = 1'b1;
    a_address    = ADDR_W'(addr);
    a_writedata  = data;
    a_byteenable = be;
    tick();
    a_chipselect = 1'b0;
    a_write      = 1'b0;
    if (addr < DEPTH) begin
      for (int b = 0; b < BE_W; b++)
        if (be[b]) bank_m[1 - act_m][addr][b*8 +: 8] = data[b*8 +: 8];
    end
  endtask

  task automatic aReadCheck(input string tag, input int addr);
    a_chipselect = 1'b1;
    a_read       = 1'b1;
    a_address    = ADDR_W'(addr);
    tick();
    a_chipselect = 1'b0;
    a_read       = 1'b0;
    checkOutput({tag, "_valid"}, 32'(a_readdatavalid), 32'd1);
    checkOutput(tag, a_readdata, expA(addr));
  endtask

  task automatic bReadCheck(input string tag, input int addr);
    b_read    = 1'b1;
    b_address = ADDR_W'(addr);
    tick();
    b_read = 1'b0;
    checkOutput({tag, "_valid"}, 32'(b_readdatavalid), 32'd1);
    checkOutput(tag, b_readdata, expB(addr));
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while (commit_busy && n < DEPTH + 20) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'(commit_busy), 32'd0);
  endtask

  task automatic fullCommit();
    commit_req = 1'b1;
    tick();
    commit_req   = 1'b0;
    b_frame_done = 1'b1;
    tick();
    b_frame_done = 1'b0;
    modelCommit();
    waitIdle("commit_done");
  endtask

  initial begin
    int cycles;
    int addr;
    int old_act;
    for (int i = 0; i < DEPTH; i++) begin
      bank_m[0][i] = '0;
      bank_m[1][i] = '0;
    end

    // Reset and reset-state outputs
    reset = 1'b1;
    repeat (3) tick();
    checkOutput("rst_active_bank", 32'(active_bank), 32'd0);
    checkOutput("rst_commit_busy", 32'(commit_busy), 32'd0);
    checkOutput("rst_waitrequest", 32'(a_waitrequest), 32'd0);
    checkOutput("rst_a_valid", 32'(a_readdatavalid), 32'd0);
    checkOutput("rst_b_valid", 32'(b_readdatavalid), 32'd0);
    checkOutput("rst_a_data", a_readdata, 32'd0);
    checkOutput("rst_b_data", b_readdata, 32'd0);
    reset = 1'b0;
    tick();

    // Zero both banks: clear shadow, commit so the copy clears the other one, then reset
    for (int i = 0; i < DEPTH; i++) applyStimulus(i, '0, '1);
    fullCommit();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    act_m = 0;
    checkOutput("init_active_bank", 32'(active_bank), 32'd0);

    // Byte-enabled write to shadow leaves the active bank untouched
    applyStimulus(5, 32'hDEADBEEF, 4'b0011);
    aReadCheck("a_be_read5", 5);
    checkOutput("a_be_value", a_readdata, 32'h0000BEEF);
    bReadCheck("b_read5_unaffected", 5);

    // Fill shadow with i, commit, frame boundary 20 cycles later
    for (int i = 0; i < DEPTH; i++) applyStimulus(i, 32'(i), '1);
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    checkOutput("pend_busy", 32'(commit_busy), 32'd1);
    checkOutput("pend_wait", 32'(a_waitrequest), 32'd1);
    a_chipselect = 1'b1;
    a_write      = 1'b1;
    a_address    = 11'd7;
    a_writedata  = 32'h0BAD0BAD;
    a_byteenable = '1;
    repeat (20) tick();
    a_chipselect = 1'b0;
    a_write      = 1'b0;
    checkOutput("pend_wait_late", 32'(a_waitrequest), 32'd1);
    b_frame_done = 1'b1;
    tick();
    b_frame_done = 1'b0;
    old_act = act_m;
    checkOutput("swap_bank_unchanged", 32'(active_bank), 32'(old_act));
    checkOutput("swap_wait", 32'(a_waitrequest), 32'd1);
    b_read    = 1'b1;
    b_address = 11'd7;
    tick();
    b_read = 1'b0;
    checkOutput("swap_b_old_bank", b_readdata, bank_m[old_act][7]);
    checkOutput("swap_toggled", 32'(active_bank), 32'(1 - old_act));
    modelCommit();
    cycles = 1;
    while (commit_busy && cycles < DEPTH + 20) begin
      addr      = $urandom_range(0, DEPTH - 1);
      b_read    = 1'b1;
      b_address = ADDR_W'(addr);
      tick();
      b_read = 1'b0;
      cycles++;
      checkOutput("copy_b_read", b_readdata, expB(addr));
    end
    checkOutput("commit_duration", 32'(cycles), 32'(DEPTH + 2));
    checkOutput("commit_busy_low", 32'(commit_busy), 32'd0);
    checkOutput("wait_low_with_busy", 32'(a_waitrequest), 32'd0);
    bReadCheck("b_read7_new", 7);
    checkOutput("b_read7_is7", b_readdata, 32'd7);
    aReadCheck("a_copyback100", 100);
    checkOutput("a_copyback_is100", a_readdata, 32'd100);
    applyStimulus(100, 32'h12345678, '1);
    bReadCheck("b_read100_stable", 100);
    aReadCheck("a_read100_edit", 100);

    // commit_req and b_frame_done together: frame pulse ignored, second commit ignored
    old_act      = act_m;
    commit_req   = 1'b1;
    b_frame_done = 1'b1;
    tick();
    commit_req   = 1'b0;
    b_frame_done = 1'b0;
    repeat (3) tick();
    checkOutput("same_cycle_pend", 32'(commit_busy), 32'd1);
    checkOutput("same_cycle_no_swap", 32'(active_bank), 32'(old_act));
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    repeat (3) tick();
    checkOutput("second_req_no_swap", 32'(active_bank), 32'(old_act));
    b_frame_done = 1'b1;
    tick();
    b_frame_done = 1'b0;
    tick();
    checkOutput("late_frame_swap", 32'(active_bank), 32'(1 - old_act));
    modelCommit();
    waitIdle("same_cycle_done");
    bReadCheck("b_after_second", 100);

    // Out-of-range handling
    applyStimulus(1025, 32'hCAFEF00D, '1);
    aReadCheck("a_read1025", 1025);
    aReadCheck("a_read1_noalias", 1);
    aReadCheck("a_read2047", 2047);
    bReadCheck("b_read2047", 2047);

    // Randomised mix of CPU writes/reads and TX reads
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 9) == 0) addr = $urandom_range(DEPTH, 2047);
      else                           addr = $urandom_range(0, DEPTH - 1);
      case ($urandom_range(0, 2))
        0:       applyStimulus(addr, $urandom, 4'($urandom_range(0, 15)));
        1:       aReadCheck("rand_a_read", addr);
        default: bReadCheck("rand_b_read", addr);
      endcase
    end
    fullCommit();
    for (int k = 0; k < 10; k++) begin
      addr = $urandom_range(0, DEPTH - 1);
      bReadCheck("rand_post_commit_b", addr);
      aReadCheck("rand_post_commit_a", addr);
    end

    // Reset in the middle of a copy (index 300)
    if (act_m != 0) fullCommit();
    commit_req = 1'b1;
    tick();
    commit_req   = 1'b0;
    b_frame_done = 1'b1;
    tick();
    b_frame_done = 1'b0;
    tick();
    repeat (300) tick();
    checkOutput("mid_copy_busy", 32'(commit_busy), 32'd1);
    checkOutput("mid_copy_bank", 32'(active_bank), 32'd1);
    reset     = 1'b1;
    b_read    = 1'b1;
    b_address = 11'd3;
    tick();
    reset  = 1'b0;
    b_read = 1'b0;
    act_m  = 0;
    checkOutput("abort_bank", 32'(active_bank), 32'd0);
    checkOutput("abort_busy", 32'(commit_busy), 32'd0);
    checkOutput("abort_wait", 32'(a_waitrequest), 32'd0);
    checkOutput("abort_b_valid", 32'(b_readdatavalid), 32'd0);
    checkOutput("abort_b_data", b_readdata, 32'd0);
    checkOutput("abort_a_valid", 32'(a_readdatavalid), 32'd0);
    checkOutput("abort_a_data", a_readdata, 32'd0);
    applyStimulus(9, 32'h5A5A1234, '1);
    aReadCheck("post_abort_a9", 9);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #5ms;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
